// File: rtl/prog_mem_pkg.sv
// Shared types and helpers for the program memory controller.
// Optional feature macro: PROG_MEM_PARITY_EN (per-word even parity).
package prog_mem_pkg;

  // Controller operating modes
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  localparam int unsigned ADDR_W_DFLT  = 8;
  localparam int unsigned CODE_W_DFLT  = 16;
  localparam int unsigned OP_W_DFLT    = 4;
  localparam int unsigned CYC_W_DFLT   = 16;
  localparam logic [3:0]  HALT_OP_DFLT = 4'hF;

  // Widest word the helpers handle; callers zero-extend into this
  localparam int unsigned PKG_MAX_W = 64;

  // Opcode field: the top op_w bits of a code_w-bit word, right-aligned
  function automatic logic [PKG_MAX_W-1:0] op_field(
    input logic [PKG_MAX_W-1:0] word,
    input int unsigned          code_w,
    input int unsigned          op_w
  );
    logic [PKG_MAX_W-1:0] mask;
    mask = ~({PKG_MAX_W{1'b1}} << op_w);
    return (word >> (code_w - op_w)) & mask;
  endfunction

  // Even parity: the bit that makes the total number of ones even
  function automatic logic even_par(input logic [PKG_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/prog_mem_if.sv
// Loader, run-control and fetch signals of the program memory controller.
// Optional feature macro: PROG_MEM_PARITY_EN adds par_err.
interface prog_mem_if
  import prog_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DFLT,
  parameter int unsigned CODE_W = CODE_W_DFLT,
  parameter int unsigned CYC_W  = CYC_W_DFLT
);

  logic              ld_start;
  logic [ADDR_W:0]   ld_len;
  logic              ld_valid;
  logic [CODE_W-1:0] ld_data;
  logic              ld_ready;
  logic              ld_done;
  logic              run_start;
  logic [ADDR_W-1:0] pc;
  logic              fetch_en;
  logic [CODE_W-1:0] code;
  logic              code_valid;
  logic              halt;
  logic [CYC_W-1:0]  cycles;
`ifdef PROG_MEM_PARITY_EN
  logic              par_err;

  modport master (
    output ld_start, ld_len, ld_valid, ld_data, run_start, pc, fetch_en,
    input  ld_ready, ld_done, code, code_valid, halt, cycles, par_err
  );

  modport slave (
    input  ld_start, ld_len, ld_valid, ld_data, run_start, pc, fetch_en,
    output ld_ready, ld_done, code, code_valid, halt, cycles, par_err
  );
`else
  modport master (
    output ld_start, ld_len, ld_valid, ld_data, run_start, pc, fetch_en,
    input  ld_ready, ld_done, code, code_valid, halt, cycles
  );

  modport slave (
    input  ld_start, ld_len, ld_valid, ld_data, run_start, pc, fetch_en,
    output ld_ready, ld_done, code, code_valid, halt, cycles
  );
`endif

endinterface

// File: rtl/prog_mem_ram.sv
// Program storage: one write port, one registered read port, no reset.
module prog_mem_ram
  import prog_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DFLT,
  parameter int unsigned DATA_W = CODE_W_DFLT
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Write on load accept; read data holds until the next read
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/prog_mem_ctrl.sv
// Program memory controller: runtime loader, registered fetch port,
// halt-opcode detection and a saturating RUN cycle counter.
// Optional feature macro: PROG_MEM_PARITY_EN (stored parity, par_err).
module prog_mem_ctrl
  import prog_mem_pkg::*;
#(
  parameter int unsigned     ADDR_W  = ADDR_W_DFLT,
  parameter int unsigned     CODE_W  = CODE_W_DFLT,
  parameter int unsigned     OP_W    = OP_W_DFLT,
  parameter logic [OP_W-1:0] HALT_OP = OP_W'(HALT_OP_DFLT),
  parameter int unsigned     CYC_W   = CYC_W_DFLT
) (
  input logic       clk,
  input logic       power,
  prog_mem_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef PROG_MEM_PARITY_EN
  localparam int unsigned MEM_W = CODE_W + 1;
`else
  localparam int unsigned MEM_W = CODE_W;
`endif
  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]  PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);
  localparam logic [CYC_W-1:0] CYC_MAX = '1;

  state_e            r_state;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_wptr;
  logic              r_ld_ready;
  logic              r_ld_done;
  logic              r_code_valid;
  logic              r_code_init;
  logic              r_halt;
  logic [CYC_W-1:0]  r_cycles;

  state_e            w_next_state;
  logic              w_accept;
  logic              w_rd_en;
  logic              w_load_done;
  logic              w_run_go;
  logic              w_halt_hit;
  logic              w_par_hit;
  logic              w_stop;
  logic [ADDR_W:0]   w_ld_len;
  logic [ADDR_W:0]   w_wptr_inc;
  logic [MEM_W-1:0]  w_wdata;
  logic [MEM_W-1:0]  w_rd_data;
  logic [CODE_W-1:0] w_code;

  assign w_ld_len   = (bus.ld_len > DEPTH_L) ? DEPTH_L : bus.ld_len;
  assign w_wptr_inc = r_wptr + PTR_ONE;
  assign w_code     = w_rd_data[CODE_W-1:0];

  // A word whose fetch completed last edge ends the run this cycle
  assign w_halt_hit = r_code_valid &&
    (op_field(PKG_MAX_W'(w_code), CODE_W, OP_W) == PKG_MAX_W'(HALT_OP));

`ifdef PROG_MEM_PARITY_EN
  logic r_par_err;

  assign w_wdata   = {even_par(PKG_MAX_W'(bus.ld_data)), bus.ld_data};
  assign w_par_hit = r_code_valid && even_par(PKG_MAX_W'(w_rd_data));

  // Parity error flag, sticky until a new load or reset
  always_ff @(posedge clk or negedge power) begin
    if (!power) begin
      r_par_err <= 1'b0;
    end else if (bus.ld_start) begin
      r_par_err <= 1'b0;
    end else if (w_par_hit) begin
      r_par_err <= 1'b1;
    end
  end

  assign bus.par_err = r_par_err | w_par_hit;
`else
  assign w_wdata   = bus.ld_data;
  assign w_par_hit = 1'b0;
`endif

  assign w_stop = w_halt_hit | w_par_hit;

  // Next-state and per-cycle strobes; ld_start overrides everything
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_rd_en      = 1'b0;
    w_load_done  = 1'b0;
    w_run_go     = 1'b0;
    if (bus.ld_start) begin
      if (w_ld_len == '0) begin
        w_next_state = ST_IDLE;
        w_load_done  = 1'b1;
      end else begin
        w_next_state = ST_LOAD;
      end
    end else begin
      case (r_state)
        ST_IDLE, ST_HALTED: begin
          if (bus.run_start) begin
            w_next_state = ST_RUN;
            w_run_go     = 1'b1;
          end
        end
        ST_LOAD: begin
          if (bus.ld_valid && r_ld_ready) begin
            w_accept = 1'b1;
            if (w_wptr_inc == r_len) begin
              w_next_state = ST_IDLE;
              w_load_done  = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_stop) begin
            w_next_state = ST_HALTED;
          end else if (bus.fetch_en) begin
            w_rd_en = 1'b1;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge power) begin
    if (!power) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Load length, write pointer and loader handshake outputs
  always_ff @(posedge clk or negedge power) begin
    if (!power) begin
      r_len      <= '0;
      r_wptr     <= '0;
      r_ld_ready <= 1'b0;
      r_ld_done  <= 1'b0;
    end else begin
      r_ld_ready <= (w_next_state == ST_LOAD);
      r_ld_done  <= w_load_done;
      if (bus.ld_start) begin
        r_len  <= w_ld_len;
        r_wptr <= '0;
      end else if (w_accept) begin
        r_wptr <= w_wptr_inc;
      end
    end
  end

  // Fetch status and sticky halt
  always_ff @(posedge clk or negedge power) begin
    if (!power) begin
      r_code_valid <= 1'b0;
      r_code_init  <= 1'b0;
      r_halt       <= 1'b0;
    end else begin
      r_code_valid <= w_rd_en;
      if (w_rd_en) begin
        r_code_init <= 1'b1;
      end
      if (bus.ld_start || w_run_go) begin
        r_halt <= 1'b0;
      end else if (w_stop) begin
        r_halt <= 1'b1;
      end
    end
  end

  // RUN cycle counter: cleared on run entry, saturating, frozen elsewhere
  always_ff @(posedge clk or negedge power) begin
    if (!power) begin
      r_cycles <= '0;
    end else if (w_run_go) begin
      r_cycles <= '0;
    end else if ((r_state == ST_RUN) && (w_next_state == ST_RUN) &&
                 (r_cycles != CYC_MAX)) begin
      r_cycles <= r_cycles + CYC_ONE;
    end
  end

  prog_mem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (MEM_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_accept),
    .i_waddr (r_wptr[ADDR_W-1:0]),
    .i_wdata (w_wdata),
    .i_re    (w_rd_en),
    .i_raddr (bus.pc),
    .o_rdata (w_rd_data)
  );

  // Code reads as zero until the first fetch after reset
  assign bus.code       = r_code_init ? w_code : '0;
  assign bus.code_valid = r_code_valid;
  assign bus.halt       = r_halt | w_stop;
  assign bus.cycles     = r_cycles;
  assign bus.ld_ready   = r_ld_ready;
  assign bus.ld_done    = r_ld_done;

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// Directed bench for prog_mem_ctrl with a scoreboard of expected fetch words.
// Optional feature macro: PROG_MEM_PARITY_EN enables the parity-error step.
module tb_prog_mem_ctrl;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned CODE_W = 16;
  localparam int unsigned CYC_W  = 16;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  logic clk = 1'b0;
  logic power;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;
  logic [15:0] exp_q[$];
  logic [15:0] words[4];
  logic        done;

  always #5 clk = ~clk;

  prog_mem_if #(.ADDR_W(ADDR_W), .CODE_W(CODE_W), .CYC_W(CYC_W)) u_if ();

  prog_mem_ctrl #(
    .ADDR_W (ADDR_W),
    .CODE_W (CODE_W),
    .OP_W   (4),
    .HALT_OP(4'hF),
    .CYC_W  (CYC_W)
  ) dut (
    .clk   (clk),
    .power (power),
    .bus   (u_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: count handshakes, then sample #1 after the edge and score fetches
  task automatic step();
    if (u_if.ld_valid && u_if.ld_ready) n_acc++;
    @(posedge clk);
    #1;
    if (u_if.code_valid) begin
      if (exp_q.size() == 0) chk("sb_unexpected_valid", 32'(u_if.code_valid), 32'd0);
      else chk("sb_code", 32'(u_if.code), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    words = '{16'h1001, 16'h2002, 16'h3003, 16'hF000};
    power = 1'b0;
    u_if.ld_start = 1'b0; u_if.ld_len = '0; u_if.ld_valid = 1'b0; u_if.ld_data = '0;
    u_if.run_start = 1'b0; u_if.pc = '0; u_if.fetch_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_code", 32'(u_if.code), 32'd0);
    chk("rst_code_valid", 32'(u_if.code_valid), 32'd0);
    chk("rst_ld_ready", 32'(u_if.ld_ready), 32'd0);
    chk("rst_ld_done", 32'(u_if.ld_done), 32'd0);
    chk("rst_halt", 32'(u_if.halt), 32'd0);
    chk("rst_cycles", 32'(u_if.cycles), 32'd0);
    power = 1'b1;

    // Load four words with ld_valid toggling
    u_if.ld_len = 9'd4; u_if.ld_start = 1'b1; step(); u_if.ld_start = 1'b0;
    chk("load_ready", 32'(u_if.ld_ready), 32'd1);
    n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      u_if.ld_valid = 1'b0; step();
      chk("load_no_done_early", 32'(u_if.ld_done), 32'd0);
      u_if.ld_valid = 1'b1; u_if.ld_data = words[i]; step();
    end
    u_if.ld_valid = 1'b0;
    chk("load_writes", 32'(n_acc), 32'd4);
    chk("load_done", 32'(u_if.ld_done), 32'd1);
    chk("load_ready_off", 32'(u_if.ld_ready), 32'd0);
    step();
    chk("load_done_pulse", 32'(u_if.ld_done), 32'd0);

    // Run and fetch back-to-back up to the halt word
    u_if.run_start = 1'b1; step(); u_if.run_start = 1'b0;
    chk("run_cycles_clr", 32'(u_if.cycles), 32'd0);
    chk("run_halt_clr", 32'(u_if.halt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      u_if.pc = 8'(i); u_if.fetch_en = 1'b1; exp_q.push_back(words[i]); step();
      chk("fetch_valid", 32'(u_if.code_valid), 32'd1);
    end
    chk("halt_set", 32'(u_if.halt), 32'd1);
    chk("halt_cycles", 32'(u_if.cycles), 32'd4);
    u_if.pc = 8'd0; step();
    chk("post_halt_valid", 32'(u_if.code_valid), 32'd0);
    chk("post_halt_code", 32'(u_if.code), 32'hF000);
    chk("post_halt_halt", 32'(u_if.halt), 32'd1);
    u_if.fetch_en = 1'b0; step();
    chk("halt_cycles_frozen", 32'(u_if.cycles), 32'd4);

    // Restart from HALTED, then async reset mid-run
    u_if.run_start = 1'b1; step(); u_if.run_start = 1'b0;
    chk("rerun_halt_clr", 32'(u_if.halt), 32'd0);
    chk("rerun_cycles_clr", 32'(u_if.cycles), 32'd0);
    u_if.pc = 8'd1; u_if.fetch_en = 1'b1; exp_q.push_back(16'h2002); step();
    u_if.fetch_en = 1'b0;
    chk("rerun_valid", 32'(u_if.code_valid), 32'd1);
    #2 power = 1'b0;
    #1;
    chk("arst_code", 32'(u_if.code), 32'd0);
    chk("arst_code_valid", 32'(u_if.code_valid), 32'd0);
    chk("arst_halt", 32'(u_if.halt), 32'd0);
    chk("arst_cycles", 32'(u_if.cycles), 32'd0);
    exp_q.delete();
    step(); power = 1'b1;

    // Async reset mid-load
    u_if.ld_len = 9'd3; u_if.ld_start = 1'b1; step(); u_if.ld_start = 1'b0;
    u_if.ld_valid = 1'b1; u_if.ld_data = 16'hE001; step();
    chk("midload_ready", 32'(u_if.ld_ready), 32'd1);
    #2 power = 1'b0;
    #1;
    chk("midload_arst_ready", 32'(u_if.ld_ready), 32'd0);
    u_if.ld_valid = 1'b0; step(); power = 1'b1;

    // Zero-length load
    u_if.ld_len = 9'd0; u_if.ld_start = 1'b1; step(); u_if.ld_start = 1'b0;
    chk("len0_done", 32'(u_if.ld_done), 32'd1);
    chk("len0_ready", 32'(u_if.ld_ready), 32'd0);
    step();
    chk("len0_done_pulse", 32'(u_if.ld_done), 32'd0);
    chk("len0_ready_after", 32'(u_if.ld_ready), 32'd0);

    // ld_start beats run_start; run_start ignored during LOAD; restart overwrites
    u_if.ld_len = 9'd3; u_if.ld_start = 1'b1; u_if.run_start = 1'b1; step();
    u_if.ld_start = 1'b0;
    chk("both_start_load", 32'(u_if.ld_ready), 32'd1);
    step(); u_if.run_start = 1'b0;
    chk("run_in_load_ignored", 32'(u_if.ld_ready), 32'd1);
    u_if.ld_valid = 1'b1; u_if.ld_data = 16'hC001; step();
    u_if.ld_data = 16'hC002; step();
    u_if.ld_valid = 1'b0;
    u_if.ld_len = 9'd2; u_if.ld_start = 1'b1; step(); u_if.ld_start = 1'b0;
    n_acc = 0;
    u_if.ld_valid = 1'b1; u_if.ld_data = 16'hD001; step();
    u_if.ld_data = 16'hD002; step();
    u_if.ld_valid = 1'b0;
    chk("restart_writes", 32'(n_acc), 32'd2);
    chk("restart_done", 32'(u_if.ld_done), 32'd1);
    u_if.run_start = 1'b1; step(); u_if.run_start = 1'b0;
    u_if.fetch_en = 1'b1;
    u_if.pc = 8'd0; exp_q.push_back(16'hD001); step();
    u_if.pc = 8'd1; exp_q.push_back(16'hD002); step();
    u_if.pc = 8'd2; exp_q.push_back(16'h3003); step();
    u_if.fetch_en = 1'b0; step();
    chk("restart_no_halt", 32'(u_if.halt), 32'd0);

    // Over-long load is clamped to DEPTH words
    u_if.ld_len = 9'(DEPTH + 5); u_if.ld_start = 1'b1; step(); u_if.ld_start = 1'b0;
    n_acc = 0; done = 1'b0; u_if.ld_valid = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      u_if.ld_data = 16'h1000 + 16'(n_acc);
      step();
      done = u_if.ld_done;
    end
    u_if.ld_valid = 1'b0;
    chk("clamp_done", 32'(done), 32'd1);
    chk("clamp_writes", 32'(n_acc), 32'(DEPTH));
    chk("clamp_ready_off", 32'(u_if.ld_ready), 32'd0);

    // Fetch outside RUN is ignored and code holds
    u_if.pc = 8'd5; u_if.fetch_en = 1'b1; step(); u_if.fetch_en = 1'b0;
    chk("idle_fetch_valid", 32'(u_if.code_valid), 32'd0);
    chk("idle_fetch_code_hold", 32'(u_if.code), 32'h3003);

    // Fetch clamped-load contents at both ends
    u_if.run_start = 1'b1; step(); u_if.run_start = 1'b0;
    u_if.fetch_en = 1'b1;
    u_if.pc = 8'd255; exp_q.push_back(16'h10FF); step();
    u_if.pc = 8'd0;   exp_q.push_back(16'h1000); step();
    u_if.fetch_en = 1'b0; step();
    chk("clamp_run_cycles", 32'(u_if.cycles), 32'd3);

`ifdef PROG_MEM_PARITY_EN
    // Corrupt the parity bit of a fetched word
    u_if.pc = 8'd0; u_if.fetch_en = 1'b1;
    @(posedge clk);
    u_if.fetch_en = 1'b0;
    force dut.w_rd_data = {1'b0, 16'h1000};
    #1;
    chk("par_valid", 32'(u_if.code_valid), 32'd1);
    chk("par_code", 32'(u_if.code), 32'h1000);
    chk("par_err", 32'(u_if.par_err), 32'd1);
    chk("par_halt", 32'(u_if.halt), 32'd1);
    @(posedge clk);
    #1;
    release dut.w_rd_data;
    chk("par_err_sticky", 32'(u_if.par_err), 32'd1);
    chk("par_halt_sticky", 32'(u_if.halt), 32'd1);
    u_if.ld_len = 9'd0; u_if.ld_start = 1'b1; step(); u_if.ld_start = 1'b0;
    chk("par_err_clr", 32'(u_if.par_err), 32'd0);
`endif

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
